// File: rtl/stopwatch_control.sv
// Stopwatch front end: button conditioning (sync, debounce, press detect),
// IDLE/RUNNING/PAUSED run FSM and the seconds prescaler feeding the BCD counter.
module stopwatch_control #(
  parameter int TICK_DIV        = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic clock,
  input  logic nRST,
  input  logic start_stop_btn,
  input  logic clear_btn,
  output logic second_tick,
  output logic clear,
  output logic running
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  // Button lanes: bit 0 = start/stop, bit 1 = clear.
  logic [1:0]    raw_btn;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    stable_q, stable_d;
  logic [1:0]    stable_prev_q;
  logic [1:0]    press_q, press_d;
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          clear_q, clear_d;
  logic          running_q, running_d;

  assign raw_btn = {clear_btn, start_stop_btn};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i]  = stable_q[i];
      deb_cnt_d[i] = '0;
      // The counter only advances while the synced level disagrees with stable.
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
    press_d = stable_q & ~stable_prev_q;
  end

  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    if (press_q[1]) begin
      state_d = IDLE;
      clear_d = 1'b1;
    end else if (press_q[0]) begin
      case (state_q)
        IDLE:    state_d = RUNNING;
        RUNNING: state_d = PAUSED;
        PAUSED:  state_d = RUNNING;
        default: state_d = IDLE;
      endcase
    end

    // Count only when RUNNING both before and after the edge, so a pause
    // freezes the prescaler and a resume edge does not advance it.
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (state_d == IDLE) begin
      presc_d = '0;
    end else if ((state_q == RUNNING) && (state_d == RUNNING)) begin
      tick_d  = (presc_q == PRESC_MAX);
      presc_d = tick_d ? '0 : presc_q + PW'(1);
    end
    running_d = (state_d == RUNNING);
  end

  always_ff @(posedge clock or negedge nRST) begin
    if (!nRST) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      press_q       <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= '0;
      end
      state_q       <= IDLE;
      presc_q       <= '0;
      tick_q        <= 1'b0;
      clear_q       <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      sync1_q       <= raw_btn;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      press_q       <= press_d;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
      state_q       <= state_d;
      presc_q       <= presc_d;
      tick_q        <= tick_d;
      clear_q       <= clear_d;
      running_q     <= running_d;
    end
  end

  assign second_tick = tick_q;
  assign clear       = clear_q;
  assign running     = running_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed bench for stopwatch_control with TICK_DIV=4, DEBOUNCE_CYCLES=3.
module tb_stopwatch_control;

  logic clock = 1'b0;
  logic nRST;
  logic start_stop_btn;
  logic clear_btn;
  logic second_tick;
  logic clear;
  logic running;

  int n_checks = 0;
  int n_pass   = 0;

  int tick_cnt = 0;
  int clr_cnt  = 0;
  int run_cnt  = 0;

  stopwatch_control #(
    .TICK_DIV       (4),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clock         (clock),
    .nRST          (nRST),
    .start_stop_btn(start_stop_btn),
    .clear_btn     (clear_btn),
    .second_tick   (second_tick),
    .clear         (clear),
    .running       (running)
  );

  // clock / reset
  always #5 clock = ~clock;

  // Pulse/level accumulators sampled mid-cycle.
  always @(negedge clock) begin
    tick_cnt <= tick_cnt + int'(second_tick);
    clr_cnt  <= clr_cnt + int'(clear);
    run_cnt  <= run_cnt + int'(running);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Called just after a posedge; raises the requested buttons and checks that
  // running changes exactly 2 sync + 3 debounce + 1 edge + 1 FSM cycles later.
  task automatic press(input logic ss, input logic clr, input logic run_before,
                       input logic run_after, input string tag);
    if (ss)  start_stop_btn = 1'b1;
    if (clr) clear_btn      = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check({tag, "_run_before"}, 32'(running), 32'(run_before));
    @(posedge clock);
    #1;
    check({tag, "_run_after"}, 32'(running), 32'(run_after));
  endtask

  initial begin
    int t0, c0, r0, n;

    nRST           = 1'b0;
    start_stop_btn = 1'b0;
    clear_btn      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_tick", 32'(second_tick), 0);
    check("rst_clear", 32'(clear), 0);
    check("rst_running", 32'(running), 0);
    nRST = 1'b1;

    // Idle with buttons low.
    t0 = tick_cnt; c0 = clr_cnt; r0 = run_cnt;
    repeat (50) @(posedge clock);
    #1;
    check("idle_ticks", 32'(tick_cnt - t0), 0);
    check("idle_clears", 32'(clr_cnt - c0), 0);
    check("idle_running", 32'(run_cnt - r0), 0);

    // Start: first tick 4 cycles after running rises, then every 4.
    press(1'b1, 1'b0, 1'b0, 1'b1, "start");
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (i == 3) start_stop_btn = 1'b0;
      check("start_tick", 32'(second_tick), 32'(i % 4 == 0));
      n += int'(second_tick);
    end
    check("start_5_ticks", 32'(n), 5);

    // Pause with the prescaler at 2, then 40 quiet cycles.
    press(1'b1, 1'b0, 1'b1, 1'b0, "pause");
    t0 = tick_cnt;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (i == 3) start_stop_btn = 1'b0;
    end
    check("pause_ticks", 32'(tick_cnt - t0), 0);
    check("pause_running", 32'(running), 0);

    // Resume: the held partial second makes the tick arrive 2 cycles in.
    press(1'b1, 1'b0, 1'b0, 1'b1, "resume");
    for (int i = 1; i <= 15; i++) begin
      @(posedge clock);
      #1;
      if (i == 3) start_stop_btn = 1'b0;
      check("resume_tick", 32'(second_tick), 32'(i % 4 == 2));
    end
    check("resume_running", 32'(running), 1);

    // Clear and start/stop together, landing where a tick would otherwise fire.
    c0 = clr_cnt;
    press(1'b1, 1'b1, 1'b1, 1'b0, "clear");
    check("clear_pulse", 32'(clear), 1);
    check("clear_no_tick", 32'(second_tick), 0);
    @(posedge clock);
    #1;
    check("clear_one_cycle", 32'(clear), 0);
    t0 = tick_cnt;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock);
      #1;
      if (i == 2) begin
        start_stop_btn = 1'b0;
        clear_btn      = 1'b0;
      end
    end
    check("clear_count", 32'(clr_cnt - c0), 1);
    check("clear_idle_ticks", 32'(tick_cnt - t0), 0);
    check("clear_idle_running", 32'(running), 0);

    // Restart: prescaler was zeroed, so ticks at 4 and 8.
    press(1'b1, 1'b0, 1'b0, 1'b1, "restart");
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock);
      #1;
      if (i == 3) start_stop_btn = 1'b0;
      check("restart_tick", 32'(second_tick), 32'(i % 4 == 0));
    end

    // Async reset between edges while second_tick is high.
    #3;
    nRST = 1'b0;
    #2;
    check("arst_tick", 32'(second_tick), 0);
    check("arst_running", 32'(running), 0);
    check("arst_clear", 32'(clear), 0);
    repeat (2) @(posedge clock);
    #1;
    nRST = 1'b1;
    t0 = tick_cnt; r0 = run_cnt; c0 = clr_cnt;
    repeat (30) @(posedge clock);
    #1;
    check("arst_after_ticks", 32'(tick_cnt - t0), 0);
    check("arst_after_running", 32'(run_cnt - r0), 0);
    check("arst_after_clears", 32'(clr_cnt - c0), 0);

    // Bounce: 2-cycle pulses are rejected, then a stable hold starts once.
    for (int r = 0; r < 5; r++) begin
      start_stop_btn = 1'b1;
      repeat (2) begin
        @(posedge clock);
        #1;
        check("bounce_hi_running", 32'(running), 0);
      end
      start_stop_btn = 1'b0;
      repeat (2) begin
        @(posedge clock);
        #1;
        check("bounce_lo_running", 32'(running), 0);
      end
    end
    press(1'b1, 1'b0, 1'b0, 1'b1, "bounce_hold");
    for (int i = 1; i <= 12; i++) begin
      @(posedge clock);
      #1;
      if (i == 3) start_stop_btn = 1'b0;
      check("bounce_stays_running", 32'(running), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
